trace_buffer_reader: RTL and testbench

- Read-side consumer of the ADC sample ring buffer in data RAM.
- Once per video frame it walks one channel's ring from the oldest sample to the newest through the RAM's read-only port.
- Each sample is scaled to a screen row and stored in a double-buffered column buffer.
- The VGA controller reads that buffer by pixel column, so the trace scrolls without tearing.

---
 rtl/trace_buffer_reader.sv | 195 +++++++++++++++++++
 tb/tb_trace_buffer_reader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer_reader.sv
// Walks one channel of the ADC sample ring once per frame, scales each sample
// to a screen row and fills the back half of a double-buffered column buffer.
module trace_buffer_reader #(
    parameter int unsigned          ADDR_W     = 12,
    parameter logic [ADDR_W-1:0]    BASE_ADDR  = 12'h801,
    parameter int unsigned          DEPTH      = 640,
    parameter int unsigned          IDX_W      = 10,
    parameter int unsigned          SCREEN_H   = 480,
    parameter int unsigned          ROW_W      = 9,
    parameter int unsigned          RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [IDX_W-1:0]  wr_index,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic [IDX_W-1:0]  pix_col,
    output logic [ROW_W-1:0]  trace_row,
    output logic              trace_valid,
    output logic              busy,
    output logic              frame_ready,
    output logic              overrun
);

    localparam int unsigned       SAMPLE_W   = 12;
    localparam int unsigned       PROD_W     = SAMPLE_W + $clog2(SCREEN_H);
    localparam logic [IDX_W-1:0]  DEPTH_I    = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0]  DEPTH_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]    DEPTH_X    = (IDX_W + 1)'(DEPTH);
    localparam logic [1:0]        LAT_LAST   = 2'(RD_LATENCY - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX    = ROW_W'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [IDX_W-1:0]   col_q, col_d;
    logic [IDX_W-1:0]   start_q, start_d;
    logic [1:0]         lat_q, lat_d;
    logic               display_bank_q, display_bank_d;
    logic               swap_pending_q, swap_pending_d;
    logic               trace_valid_q, trace_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [ROW_W-1:0]   trace_row_q;

    logic [IDX_W:0]         idx_sum;
    logic [IDX_W:0]         idx_wrap;
    logic [SAMPLE_W-1:0]    sample;
    logic [PROD_W-1:0]      prod;
    logic [ROW_W-1:0]       row;
    logic                   bank_we;

    logic [ROW_W-1:0] bank0 [DEPTH];
    logic [ROW_W-1:0] bank1 [DEPTH];

    // Ring index wraps with a single compare-and-subtract; start + col < 2*DEPTH.
    always_comb begin
        idx_sum  = {1'b0, start_q} + {1'b0, col_q};
        idx_wrap = idx_sum;
        if (idx_sum >= DEPTH_X) begin
            idx_wrap = idx_sum - DEPTH_X;
        end
    end

    assign sample = mem_data[15:4];
    assign prod   = PROD_W'(sample) * PROD_W'(SCREEN_H);
    assign row    = ROW_MAX - ROW_W'(prod >> SAMPLE_W);

    logic unused_mem_bits;
    assign unused_mem_bits = ^{mem_data[31:16], mem_data[3:0]};

    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        col_d          = col_q;
        start_d        = start_q;
        lat_d          = lat_q;
        display_bank_d = display_bank_q;
        swap_pending_d = swap_pending_q;
        trace_valid_d  = trace_valid_q;
        busy_d         = busy_q;
        overrun_d      = frame_start && (state_q != IDLE);
        bank_we        = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (swap_pending_q) begin
                        display_bank_d = ~display_bank_q;
                        trace_valid_d  = 1'b1;
                        swap_pending_d = 1'b0;
                    end
                    start_d = (wr_index >= DEPTH_I) ? '0 : wr_index;
                    col_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr_d = BASE_ADDR + ADDR_W'(idx_wrap);
                lat_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = STORE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            STORE: begin
                bank_we = 1'b1;
                if (col_q == DEPTH_LAST) begin
                    state_d = DONE;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            DONE: begin
                swap_pending_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            mem_addr_q     <= BASE_ADDR;
            col_q          <= '0;
            start_q        <= '0;
            lat_q          <= '0;
            display_bank_q <= 1'b0;
            swap_pending_q <= 1'b0;
            trace_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            col_q          <= col_d;
            start_q        <= start_d;
            lat_q          <= lat_d;
            display_bank_q <= display_bank_d;
            swap_pending_q <= swap_pending_d;
            trace_valid_q  <= trace_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    // Fills always target the bank not on display, so reads never collide.
    always_ff @(posedge clock) begin
        if (bank_we) begin
            if (display_bank_q) begin
                bank0[col_q] <= row;
            end else begin
                bank1[col_q] <= row;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trace_row_q <= '0;
        end else if (pix_col >= DEPTH_I) begin
            trace_row_q <= '1;
        end else if (display_bank_q) begin
            trace_row_q <= bank1[pix_col];
        end else begin
            trace_row_q <= bank0[pix_col];
        end
    end

    assign mem_addr    = mem_addr_q;
    assign trace_row   = trace_row_q;
    assign trace_valid = trace_valid_q;
    assign busy        = busy_q;
    assign frame_ready = (state_q == DONE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_trace_buffer_reader.sv
// Self-checking bench for trace_buffer_reader: behavioural RAM, scoreboard of
// expected read addresses and expected displayed rows.
module tb_trace_buffer_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  wr_index = '0;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;
  logic [9:0]  pix_col = '0;
  logic [8:0]  trace_row;
  logic        trace_valid;
  logic        busy;
  logic        frame_ready;
  logic        overrun;

  trace_buffer_reader #(
    .ADDR_W    (12),
    .BASE_ADDR (12'h801),
    .DEPTH     (640),
    .IDX_W     (10),
    .SCREEN_H  (480),
    .ROW_W     (9),
    .RD_LATENCY(1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .wr_index   (wr_index),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .pix_col    (pix_col),
    .trace_row  (trace_row),
    .trace_valid(trace_valid),
    .busy       (busy),
    .frame_ready(frame_ready),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  logic [31:0] ram [0:4095];
  always @(posedge clock) mem_data <= ram[mem_addr];

  int checks = 0;
  int errors = 0;

  logic [8:0]  disp_rows [640];
  logic [8:0]  back_rows [640];
  logic [11:0] obs_addr  [640];
  bit          swap_pend = 1'b0;
  bit          valid_exp = 1'b0;
  logic [11:0] addr_q [$];
  logic [8:0]  rd_q [$];

  function automatic logic [8:0] row_of(input logic [31:0] d);
    int s;
    s = int'(d[15:4]);
    return 9'(479 - (s * 480) / 4096);
  endfunction

  task automatic randomize_ram();
    for (int i = 0; i < 4096; i++) ram[i] = $urandom;
  endtask

  // Runs one fill from IDLE; optionally injects a frame_start or a reset.
  task automatic do_fill(input logic [9:0] wi, input int inj_at, input int abort_at,
                         input string name);
    int start;
    int ov_cnt = 0;
    int busy_bad = 0;
    int fr_bad = 0;
    int k;
    logic [11:0] a;
    logic [11:0] exp_a;
    if (swap_pend) begin
      disp_rows = back_rows;
      valid_exp = 1'b1;
      swap_pend = 1'b0;
    end
    start = (wi >= 10'd640) ? 0 : int'(wi);
    addr_q.delete();
    for (int c = 0; c < 640; c++) begin
      a = 12'(12'h801 + (start + c) % 640);
      addr_q.push_back(a);
      back_rows[c] = row_of(ram[a]);
    end
    wr_index    = wi;
    frame_start = 1'b1;
    for (int n = 1; n <= 1925; n++) begin
      @(negedge clock);
      if (n == 1) begin
        frame_start = 1'b0;
        checks++;
        if (trace_valid !== valid_exp) begin
          errors++;
          $display("FAIL %s trace_valid_at_start: got %b expected %b", name, trace_valid, valid_exp);
        end
      end
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || trace_valid !== 1'b0 || mem_addr !== 12'h801) begin
          errors++;
          $display("FAIL %s reset_abort: got busy %b valid %b addr %h expected 0 0 801",
                   name, busy, trace_valid, mem_addr);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        swap_pend = 1'b0;
        valid_exp = 1'b0;
        addr_q.delete();
        return;
      end
      if (n <= 1921 && busy !== 1'b1) busy_bad++;
      if (frame_ready !== (n == 1921)) fr_bad++;
      if (overrun === 1'b1) ov_cnt++;
      if (inj_at > 0 && n == inj_at + 1) begin
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL %s overrun_pulse: got %b expected 1", name, overrun);
        end
      end
      if (n >= 3 && (n - 3) % 3 == 0 && (n - 3) / 3 < 640) begin
        k = (n - 3) / 3;
        exp_a = addr_q.pop_front();
        obs_addr[k] = mem_addr;
        checks++;
        if (mem_addr !== exp_a) begin
          errors++;
          $display("FAIL %s addr col %0d: got %h expected %h", name, k, mem_addr, exp_a);
        end
      end
      if (inj_at > 0 && n == inj_at) frame_start = 1'b1;
      else if (inj_at > 0 && n == inj_at + 1) frame_start = 1'b0;
    end
    swap_pend = 1'b1;
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_during_fill: got %0d low cycles expected 0", name, busy_bad);
    end
    checks++;
    if (fr_bad != 0) begin
      errors++;
      $display("FAIL %s frame_ready_timing: got %0d wrong cycles expected 0 (pulse at 1921)", name, fr_bad);
    end
    checks++;
    if (ov_cnt != ((inj_at > 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s overrun_count: got %0d expected %0d", name, ov_cnt, (inj_at > 0) ? 1 : 0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_fill: got %b expected 0", name, busy);
    end
  endtask

  task automatic rd(input logic [9:0] c, input logic [8:0] exp, input string name);
    logic [8:0] e;
    pix_col = c;
    rd_q.push_back(exp);
    @(negedge clock);
    e = rd_q.pop_front();
    checks++;
    if (trace_row !== e) begin
      errors++;
      $display("FAIL %s trace_row col %0d: got %h expected %h", name, c, trace_row, e);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pix_col = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (mem_addr !== 12'h801) begin
      errors++;
      $display("FAIL reset mem_addr: got %h expected 801", mem_addr);
    end
    checks++;
    if (trace_row !== 9'd0) begin
      errors++;
      $display("FAIL reset trace_row: got %h expected 000", trace_row);
    end
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset trace_valid: got %b expected 0", trace_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: got %b expected 0", busy);
    end
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset frame_ready: got %b expected 0", frame_ready);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset overrun: got %b expected 0", overrun);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_scaling();
    randomize_ram();
    ram[12'h801] = 32'h0000FFF0;
    ram[12'h802] = 32'h00000000;
    ram[12'h803] = 32'h00008000;
    do_fill(10'd0, 0, 0, "scaling");
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL scaling trace_valid_before_swap: got %b expected 0", trace_valid);
    end
  endtask

  task automatic test_wrap();
    randomize_ram();
    do_fill(10'd100, 0, 0, "wrap");
    checks++;
    if (obs_addr[0] !== 12'h865) begin
      errors++;
      $display("FAIL wrap col0: got %h expected 865", obs_addr[0]);
    end
    checks++;
    if (obs_addr[539] !== 12'hA80) begin
      errors++;
      $display("FAIL wrap col539: got %h expected a80", obs_addr[539]);
    end
    checks++;
    if (obs_addr[540] !== 12'h801) begin
      errors++;
      $display("FAIL wrap col540: got %h expected 801", obs_addr[540]);
    end
    checks++;
    if (obs_addr[639] !== 12'h864) begin
      errors++;
      $display("FAIL wrap col639: got %h expected 864", obs_addr[639]);
    end
    rd(10'd0, 9'd0,   "scaling_row");
    rd(10'd1, 9'd479, "scaling_row");
    rd(10'd2, 9'd239, "scaling_row");
    for (int i = 0; i < 4; i++) begin
      int c;
      c = $urandom_range(3, 639);
      rd(10'(c), disp_rows[c], "wrap_disp");
    end
  endtask

  task automatic test_overrun();
    randomize_ram();
    do_fill(10'd37, 500, 0, "overrun");
    checks++;
    if (trace_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun trace_valid: got %b expected 1", trace_valid);
    end
    for (int i = 0; i < 6; i++) begin
      int c;
      c = $urandom_range(0, 639);
      rd(10'(c), disp_rows[c], "overrun_no_swap");
    end
  endtask

  task automatic test_boundary();
    randomize_ram();
    do_fill(10'd700, 0, 0, "boundary");
    checks++;
    if (obs_addr[0] !== 12'h801) begin
      errors++;
      $display("FAIL boundary col0: got %h expected 801", obs_addr[0]);
    end
    checks++;
    if (obs_addr[639] !== 12'hA80) begin
      errors++;
      $display("FAIL boundary col639: got %h expected a80", obs_addr[639]);
    end
    rd(10'd640,  9'h1FF, "offscreen");
    rd(10'd1023, 9'h1FF, "offscreen");
    rd(10'd0,    disp_rows[0],   "boundary_disp");
    rd(10'd639,  disp_rows[639], "boundary_disp");
  endtask

  task automatic test_reset_abort();
    randomize_ram();
    do_fill(10'd5, 0, 300, "abort");
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort trace_valid_after_reset: got %b expected 0", trace_valid);
    end
    randomize_ram();
    do_fill(10'd200, 0, 0, "abort_fill1");
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort trace_valid_after_fill1: got %b expected 0", trace_valid);
    end
    randomize_ram();
    do_fill(10'd0, 0, 0, "abort_fill2");
    for (int c = 0; c < 640; c++) rd(10'(c), disp_rows[c], "abort_readback");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    @(negedge clock);
    test_reset();
    test_scaling();
    test_wrap();
    test_overrun();
    test_boundary();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
